// File: rtl/quad_ctrl.sv
// Quadrature encoder decoder: synchronizes A/B, accumulates steps into detents,
// and drives a saturating position count with a strobe, direction and sticky error.
module quad_ctrl #(
  parameter int POS_WIDTH = 8,
  parameter int POS_MAX   = 255,
  parameter int DETENT    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic                 stb_o,
  output logic                 dir_o,
  output logic [POS_WIDTH-1:0] pos_o,
  output logic                 err_o
);

  localparam logic signed [3:0]     DET_P   = 4'(DETENT);
  localparam logic signed [3:0]     DET_N   = -DET_P;
  localparam logic [POS_WIDTH-1:0]  POS_TOP = POS_WIDTH'(POS_MAX);

  logic [1:0]        sync1, sync2, prev;
  logic              vld1, vld2, primed;
  logic signed [3:0] sub;

  logic [1:0]           ph_cur, ph_prev, delta;
  logic                 fwd, bwd, ill;
  logic signed [3:0]    sub_step, sub_nxt;
  logic                 stb_nxt, dir_nxt, err_nxt;
  logic [POS_WIDTH-1:0] pos_nxt;

  // Map {a,b} to a cyclic phase index so a forward step is always +1 mod 4.
  always_comb begin
    ph_cur  = {sync2[1], sync2[1] ^ sync2[0]};
    ph_prev = {prev[1], prev[1] ^ prev[0]};
    delta   = ph_cur - ph_prev;
    fwd     = primed && (delta == 2'd1);
    bwd     = primed && (delta == 2'd3);
    ill     = primed && (delta == 2'd2);
  end

  always_comb begin
    sub_nxt  = sub;
    stb_nxt  = 1'b0;
    dir_nxt  = dir_o;
    pos_nxt  = pos_o;
    err_nxt  = err_o;
    sub_step = sub;
    if (fwd)
      sub_step = sub + 4'sd1;
    else if (bwd)
      sub_step = sub - 4'sd1;

    if (clr_i) begin
      pos_nxt = '0;
      sub_nxt = '0;
      err_nxt = 1'b0;
    end else if (!en_i) begin
      sub_nxt = '0;
    end else if (ill) begin
      err_nxt = 1'b1;
      sub_nxt = '0;
    end else if (sub_step == DET_P) begin
      stb_nxt = 1'b1;
      dir_nxt = 1'b1;
      sub_nxt = '0;
      if (pos_o != POS_TOP)
        pos_nxt = pos_o + 1'b1;
    end else if (sub_step == DET_N) begin
      stb_nxt = 1'b1;
      dir_nxt = 1'b0;
      sub_nxt = '0;
      if (pos_o != '0)
        pos_nxt = pos_o - 1'b1;
    end else begin
      sub_nxt = sub_step;
    end
  end

  // primed trails the synchronizer valid so the first real sample only loads prev.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      prev   <= 2'b00;
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      primed <= 1'b0;
      sub    <= '0;
      stb_o  <= 1'b0;
      dir_o  <= 1'b0;
      pos_o  <= '0;
      err_o  <= 1'b0;
    end else begin
      sync1  <= {a_i, b_i};
      sync2  <= sync1;
      prev   <= sync2;
      vld1   <= 1'b1;
      vld2   <= vld1;
      primed <= vld2;
      sub    <= sub_nxt;
      stb_o  <= stb_nxt;
      dir_o  <= dir_nxt;
      pos_o  <= pos_nxt;
      err_o  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_quad_ctrl.sv
// Randomized bench for quad_ctrl against a phase-index / detent-count reference model.
module tb_quad_ctrl;

  localparam int DET  = 4;
  localparam int PMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0, b = 1'b0, en = 1'b1, clr = 1'b0;
  logic       stb_o, dir_o, err_o;
  logic [7:0] pos_o;

  int checks = 0;
  int failures = 0;
  int stb_seen = 0;

  int m_pos = 0, m_sub = 0, m_dir = 0, m_err = 0, m_stb = 0;
  logic [1:0] hq[$];

  int e = 0;
  logic en_v = 1'b1;

  quad_ctrl #(.POS_WIDTH(8), .POS_MAX(PMAX), .DETENT(DET)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .en_i(en), .clr_i(clr),
    .stb_o(stb_o), .dir_o(dir_o), .pos_o(pos_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ph(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Decision at an edge uses the inputs seen two and three edges earlier.
  task automatic model_step();
    int d;
    m_stb = 0;
    if (!rst) begin
      hq.delete();
      m_pos = 0; m_sub = 0; m_dir = 0; m_err = 0;
      return;
    end
    hq.push_back({a, b});
    d = 0;
    if (hq.size() == 4) begin
      d = (ph(hq[1]) - ph(hq[0]) + 4) % 4;
      void'(hq.pop_front());
    end
    if (clr) begin
      m_pos = 0; m_sub = 0; m_err = 0;
    end else if (!en) begin
      m_sub = 0;
    end else if (d == 2) begin
      m_err = 1; m_sub = 0;
    end else begin
      if (d == 1) m_sub++;
      if (d == 3) m_sub--;
      if (m_sub == DET) begin
        m_stb = 1; m_dir = 1; m_sub = 0;
        m_pos = (m_pos < PMAX) ? m_pos + 1 : PMAX;
      end else if (m_sub == -DET) begin
        m_stb = 1; m_dir = 0; m_sub = 0;
        m_pos = (m_pos > 0) ? m_pos - 1 : 0;
      end
    end
  endtask

  task automatic cyc(input logic c);
    {a, b} = code(e);
    en = en_v;
    clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("stb", int'(stb_o), m_stb);
    check("dir", int'(dir_o), m_dir);
    check("pos", int'(pos_o), m_pos);
    check("err", int'(err_o), m_err);
    if (stb_o) stb_seen++;
  endtask

  task automatic step(input int d, input int hold);
    e += d;
    repeat (hold) cyc(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) cyc(1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int r, guard;

    do_reset(3);
    check("rst_pos", int'(pos_o), 0);
    check("rst_err", int'(err_o), 0);
    repeat (4) cyc(1'b0);

    // One forward detent from 00.
    stb_seen = 0;
    repeat (4) step(1, 2);
    repeat (4) cyc(1'b0);
    check("det_stb_count", stb_seen, 1);
    check("det_pos", int'(pos_o), 1);
    check("det_dir", int'(dir_o), 1);

    // Jitter cancels: +2, -2, +4 gives exactly one detent.
    cyc(1'b1);
    stb_seen = 0;
    repeat (2) step(1, 2);
    repeat (2) step(-1, 2);
    repeat (4) step(1, 2);
    repeat (4) cyc(1'b0);
    check("jit_stb_count", stb_seen, 1);
    check("jit_pos", int'(pos_o), 1);
    check("jit_err", int'(err_o), 0);

    // Illegal jump is sticky until cleared.
    stb_seen = 0;
    step(2, 8);
    check("ill_err", int'(err_o), 1);
    check("ill_stb_count", stb_seen, 0);
    step(1, 4);
    check("ill_sticky", int'(err_o), 1);
    cyc(1'b1);
    cyc(1'b0);
    check("clr_err", int'(err_o), 0);
    check("clr_pos", int'(pos_o), 0);

    // Reset released while both phases are high.
    e = 2;
    do_reset(3);
    repeat (6) cyc(1'b0);
    check("rst11_err", int'(err_o), 0);
    check("rst11_pos", int'(pos_o), 0);
    stb_seen = 0;
    repeat (4) step(1, 2);
    repeat (4) cyc(1'b0);
    check("rst11_pos_after", int'(pos_o), 1);
    check("rst11_stb_count", stb_seen, 1);

    // Disabled counting across a full detent.
    stb_seen = 0;
    en_v = 1'b0;
    repeat (4) step(1, 2);
    repeat (4) cyc(1'b0);
    en_v = 1'b1;
    check("dis_stb_count", stb_seen, 0);
    check("dis_pos", int'(pos_o), 1);

    // Clear on the detent-completing edge wins over the strobe.
    repeat (3) step(1, 2);
    e += 1;
    cyc(1'b0);
    cyc(1'b0);
    stb_seen = 0;
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    check("clrdet_stb_count", stb_seen, 0);
    check("clrdet_pos", int'(pos_o), 0);

    // Walk up to saturation, then push past it.
    guard = 0;
    while (m_pos < PMAX && guard < 20000) begin
      r = $urandom_range(0, 9);
      step((r == 0) ? -1 : 1, $urandom_range(1, 3));
      guard++;
    end
    check("sat_up_reached", m_pos, PMAX);
    stb_seen = 0;
    repeat (8) step(1, 2);
    repeat (4) cyc(1'b0);
    check("sat_up_pos", int'(pos_o), PMAX);
    check("sat_up_dir", int'(dir_o), 1);
    check("sat_up_stb", int'(stb_seen > 0), 1);

    guard = 0;
    while (m_pos > 0 && guard < 20000) begin
      r = $urandom_range(0, 9);
      step((r == 0) ? 1 : -1, $urandom_range(1, 3));
      guard++;
    end
    check("sat_dn_reached", m_pos, 0);
    stb_seen = 0;
    repeat (8) step(-1, 2);
    repeat (4) cyc(1'b0);
    check("sat_dn_pos", int'(pos_o), 0);
    check("sat_dn_dir", int'(dir_o), 0);
    check("sat_dn_stb", int'(stb_seen > 0), 1);

    // Random mix of steps, jitter, enable, clears, illegal jumps and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       do_reset(2);
      else if (r < 5)  cyc(1'b1);
      else if (r < 8)  step(2, $urandom_range(1, 3));
      else if (r < 14) begin en_v = ~en_v; cyc(1'b0); end
      else             step(($urandom_range(0, 9) < 6) ? 1 : -1, $urandom_range(1, 3));
    end
    en_v = 1'b1;
    repeat (5) cyc(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
